// File: rtl/ycr_tcm_sched.sv
// Round-robin arbiter that shares one TCM controller port between imem, dmem and debug.
// One transaction is in flight at a time: grant, request handshake, then a bounded wait for the response.
module ycr_tcm_sched #(
   parameter int unsigned TIMEOUT = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] port_req,
   output logic [2:0] port_req_ack,
   output logic [5:0] port_resp,
   output logic       mem_req,
   input  logic       mem_req_ack,
   input  logic [1:0] mem_resp,
   output logic [1:0] gnt,
   output logic       gnt_vld,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   localparam logic [1:0] RESP_ER = 2'd2;
   localparam logic [1:0] NO_GNT  = 2'd3;
   localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [1:0] gnt_q, gnt_d;
   logic [1:0] last_gnt_q, last_gnt_d;
   logic       gnt_vld_q, gnt_vld_d;
   logic [7:0] cnt_q, cnt_d;

   logic [1:0] rr_p0, rr_p1, rr_p2;
   logic [1:0] rr_gnt;
   logic [2:0] sel_vec;
   logic       gnt_req;
   logic       timeout_hit;
   logic [1:0] resp_val;

   // Search order starts just after the last served port, so that port drops to lowest priority.
   always_comb begin
      rr_p0 = 2'd0;
      rr_p1 = 2'd1;
      rr_p2 = 2'd2;
      case (last_gnt_q)
         2'd0: begin
            rr_p0 = 2'd1;
            rr_p1 = 2'd2;
            rr_p2 = 2'd0;
         end
         2'd1: begin
            rr_p0 = 2'd2;
            rr_p1 = 2'd0;
            rr_p2 = 2'd1;
         end
         default: ;
      endcase
      rr_gnt = NO_GNT;
      if (port_req[rr_p0])
         rr_gnt = rr_p0;
      else if (port_req[rr_p1])
         rr_gnt = rr_p1;
      else if (port_req[rr_p2])
         rr_gnt = rr_p2;
   end

   always_comb begin
      sel_vec = 3'b000;
      case (gnt_q)
         2'd0:    sel_vec = 3'b001;
         2'd1:    sel_vec = 3'b010;
         2'd2:    sel_vec = 3'b100;
         default: sel_vec = 3'b000;
      endcase
      gnt_req     = |(port_req & sel_vec);
      timeout_hit = (state_q == ST_WAIT) && (mem_resp == 2'd0) && (cnt_q == CNT_MAX);
      resp_val    = timeout_hit ? RESP_ER : mem_resp;
   end

   // Outputs are forced to their idle values while reset is held, even before the flops clear.
   always_comb begin
      mem_req      = 1'b0;
      port_req_ack = 3'b000;
      port_resp    = 6'd0;
      timeout_err  = 1'b0;
      gnt          = gnt_q;
      gnt_vld      = gnt_vld_q;
      if (rst) begin
         gnt     = NO_GNT;
         gnt_vld = 1'b0;
      end else begin
         case (state_q)
            ST_ACTIVE: begin
               mem_req = gnt_req;
               if (gnt_req && mem_req_ack)
                  port_req_ack = sel_vec;
            end
            ST_WAIT: begin
               port_resp   = {resp_val, resp_val, resp_val}
                           & {{2{sel_vec[2]}}, {2{sel_vec[1]}}, {2{sel_vec[0]}}};
               timeout_err = timeout_hit;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gnt_vld_d  = gnt_vld_q;
      last_gnt_d = last_gnt_q;
      cnt_d      = cnt_q;
      case (state_q)
         ST_IDLE: begin
            gnt_d     = NO_GNT;
            gnt_vld_d = 1'b0;
            if (port_req != 3'b000) begin
               gnt_d     = rr_gnt;
               gnt_vld_d = 1'b1;
               state_d   = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (!gnt_req) begin
               last_gnt_d = gnt_q;
               gnt_d      = NO_GNT;
               gnt_vld_d  = 1'b0;
               state_d    = ST_IDLE;
            end else if (mem_req_ack) begin
               cnt_d   = 8'd0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q != CNT_MAX)
               cnt_d = cnt_q + 8'd1;
            if ((mem_resp != 2'd0) || timeout_hit) begin
               last_gnt_d = gnt_q;
               gnt_d      = NO_GNT;
               gnt_vld_d  = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            gnt_d     = NO_GNT;
            gnt_vld_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= NO_GNT;
         gnt_vld_q  <= 1'b0;
         last_gnt_q <= 2'd2;
         cnt_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_vld_q  <= gnt_vld_d;
         last_gnt_q <= last_gnt_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_ycr_tcm_sched.sv
// Scoreboard bench for ycr_tcm_sched: the driver pushes expected grants, acks and responses,
// and a negedge monitor pops and compares them whenever the DUT presents one.
module tb_ycr_tcm_sched;

   localparam int TIMEOUT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] port_req;
   logic [2:0] port_req_ack;
   logic [5:0] port_resp;
   logic       mem_req;
   logic       mem_req_ack;
   logic [1:0] mem_resp;
   logic [1:0] gnt;
   logic       gnt_vld;
   logic       timeout_err;

   ycr_tcm_sched #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .port_req     (port_req),
      .port_req_ack (port_req_ack),
      .port_resp    (port_resp),
      .mem_req      (mem_req),
      .mem_req_ack  (mem_req_ack),
      .mem_resp     (mem_resp),
      .gnt          (gnt),
      .gnt_vld      (gnt_vld),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] vec;
      int         ack_dly;
      int         resp_dly;
      logic [1:0] resp_val;
      bit         drop;
      bit         rst_mid;
   } txn_t;

   int         n_cmp = 0;
   int         n_err = 0;
   int         last_gnt_m = 2;
   logic       prev_vld = 1'b0;
   logic [1:0] gnt_exp_q[$];
   logic [2:0] ack_exp_q[$];
   logic [5:0] resp_exp_q[$];
   bit         to_exp_q[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic report_unexpected(input string name, input logic [7:0] act);
      n_cmp++;
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected no event (t=%0t)", name, act, $time);
   endtask

   // Round robin: first requesting port after the last one served, wrapping modulo 3.
   function automatic int model_pick(input logic [2:0] vec, input int last);
      for (int off = 1; off <= 3; off++) begin
         int p;
         p = (last + off) % 3;
         if (((vec >> p) & 3'b001) != 3'b000)
            return p;
      end
      return 3;
   endfunction

   task automatic check_output(input string tag);
      check({tag, "_gnt"}, 8'(gnt), 8'd3);
      check({tag, "_gnt_vld"}, 8'(gnt_vld), 8'd0);
      check({tag, "_mem_req"}, 8'(mem_req), 8'd0);
      check({tag, "_ack"}, 8'(port_req_ack), 8'd0);
      check({tag, "_resp"}, 8'(port_resp), 8'd0);
      check({tag, "_timeout_err"}, 8'(timeout_err), 8'd0);
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      port_req    = 3'b000;
      mem_req_ack = 1'b0;
      mem_resp    = 2'd0;
      @(posedge clk);
      #1 rst = 1'b0;
      last_gnt_m = 2;
      gnt_exp_q.delete();
      ack_exp_q.delete();
      resp_exp_q.delete();
      to_exp_q.delete();
   endtask

   task automatic apply_stimulus(input txn_t t);
      int         g;
      logic [2:0] sel;
      bit         responded;
      g   = model_pick(t.vec, last_gnt_m);
      sel = 3'b001 << g;
      gnt_exp_q.push_back(2'(g));
      port_req    = t.vec;
      mem_resp    = 2'd0;
      mem_req_ack = 1'b0;
      @(posedge clk);
      #1;
      check("grant_latency", 8'(gnt_vld), 8'd1);
      if (gnt_vld !== 1'b1) begin
         do_reset();
         return;
      end
      repeat (t.ack_dly) begin
         mem_resp = 2'($urandom_range(0, 3));
         #1 check("mem_req_active", 8'(mem_req), 8'd1);
         @(posedge clk);
         #1;
      end
      mem_resp = 2'd0;
      if (t.drop) begin
         port_req = t.vec & ~sel;
         #1;
         check("mem_req_drop", 8'(mem_req), 8'd0);
         check("ack_drop", 8'(port_req_ack), 8'd0);
         @(posedge clk);
         #1;
         check("idle_after_drop", 8'(gnt_vld), 8'd0);
         last_gnt_m = g;
         return;
      end
      ack_exp_q.push_back(sel);
      mem_req_ack = 1'b1;
      #1 check("mem_req_accept", 8'(mem_req), 8'd1);
      @(posedge clk);
      #1 mem_req_ack = 1'b0;
      if (t.rst_mid) begin
         rst      = 1'b1;
         mem_resp = 2'd1;
         @(negedge clk);
         check_output("rst_mid");
         @(posedge clk);
         #1 rst = 1'b0;
         port_req = 3'b000;
         check("rst_release_gnt", 8'(gnt), 8'd3);
         check("rst_release_vld", 8'(gnt_vld), 8'd0);
         @(posedge clk);
         #1 mem_resp = 2'd0;
         last_gnt_m = 2;
         return;
      end
      responded = 1'b0;
      for (int k = 1; k <= TIMEOUT; k++) begin
         if (k == t.resp_dly + 1) begin
            mem_resp = t.resp_val;
            resp_exp_q.push_back(6'(t.resp_val) << (2 * g));
            responded = 1'b1;
         end else begin
            mem_resp = 2'd0;
            if (k == TIMEOUT) begin
               resp_exp_q.push_back(6'd2 << (2 * g));
               to_exp_q.push_back(1'b1);
            end
         end
         #1 check("mem_req_wait", 8'(mem_req), 8'd0);
         @(posedge clk);
         #1;
         if (responded)
            break;
      end
      mem_resp   = 2'd0;
      last_gnt_m = g;
      check("bubble_vld", 8'(gnt_vld), 8'd0);
      check("bubble_gnt", 8'(gnt), 8'd3);
   endtask

   // Monitor: every presented grant, ack, response or timeout pulse must match the next expectation.
   always @(negedge clk) begin
      if (gnt_vld && !prev_vld) begin
         if (gnt_exp_q.size() == 0)
            report_unexpected("unexpected_grant", 8'(gnt));
         else
            check("grant_port", 8'(gnt), 8'(gnt_exp_q.pop_front()));
      end
      prev_vld = gnt_vld;
      if (port_req_ack != 3'b000) begin
         if (ack_exp_q.size() == 0)
            report_unexpected("unexpected_ack", 8'(port_req_ack));
         else
            check("req_ack", 8'(port_req_ack), 8'(ack_exp_q.pop_front()));
      end
      if (port_resp != 6'd0) begin
         if (resp_exp_q.size() == 0)
            report_unexpected("unexpected_resp", 8'(port_resp));
         else
            check("port_resp", 8'(port_resp), 8'(resp_exp_q.pop_front()));
      end
      if (timeout_err) begin
         if (to_exp_q.size() == 0)
            report_unexpected("unexpected_timeout", 8'(timeout_err));
         else
            check("timeout_err", 8'(timeout_err), 8'(to_exp_q.pop_front()));
      end
   end

   txn_t dir[11] = '{
      '{3'b111, 1, 1, 2'd1, 1'b0, 1'b0},
      '{3'b111, 1, 1, 2'd1, 1'b0, 1'b0},
      '{3'b111, 1, 1, 2'd1, 1'b0, 1'b0},
      '{3'b111, 1, 1, 2'd1, 1'b0, 1'b0},
      '{3'b111, 1, 1, 2'd1, 1'b0, 1'b0},
      '{3'b001, 1, 1, 2'd1, 1'b0, 1'b0},
      '{3'b010, 0, 9, 2'd1, 1'b0, 1'b0},
      '{3'b110, 0, 0, 2'd2, 1'b0, 1'b0},
      '{3'b011, 1, 0, 2'd1, 1'b1, 1'b0},
      '{3'b010, 0, 2, 2'd1, 1'b0, 1'b0},
      '{3'b010, 0, 0, 2'd1, 1'b0, 1'b1}
   };

   initial begin
      txn_t t;
      rst         = 1'b1;
      port_req    = 3'b000;
      mem_req_ack = 1'b0;
      mem_resp    = 2'd0;
      @(negedge clk);
      check_output("reset");
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      check("post_reset_gnt", 8'(gnt), 8'd3);
      check("post_reset_vld", 8'(gnt_vld), 8'd0);

      foreach (dir[i])
         apply_stimulus(dir[i]);

      for (int n = 0; n < 80; n++) begin
         t.vec      = 3'($urandom_range(1, 7));
         t.ack_dly  = $urandom_range(0, 3);
         t.resp_dly = $urandom_range(0, 5);
         t.resp_val = 2'($urandom_range(1, 2));
         t.drop     = ($urandom_range(0, 99) < 15);
         t.rst_mid  = !t.drop && ($urandom_range(0, 99) < 6);
         apply_stimulus(t);
      end

      port_req = 3'b000;
      repeat (4) @(posedge clk);
      #1;
      check("leftover_grants", 8'(gnt_exp_q.size()), 8'd0);
      check("leftover_acks", 8'(ack_exp_q.size()), 8'd0);
      check("leftover_resps", 8'(resp_exp_q.size()), 8'd0);
      check("leftover_timeouts", 8'(to_exp_q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ycr_tcm_sched.md
YCR_TCM_SCHED -- requirements
Module: ycr_tcm_sched

Interface
REQ-001 Parameter TIMEOUT, default 32, SHALL set the maximum number of WAIT cycles allowed for a response; legal range 2..255.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 port_req  input  3  request per port; bit0 imem, bit1 dmem, bit2 debug.
REQ-006 port_req_ack  output  3  request accept, routed to the granted port only.
REQ-007 port_resp  output  6  2-bit response per port, packed as {p2,p1,p0}; encoding 0 NOTRDY, 1 RDY_OK, 2 RDY_ER.
REQ-008 mem_req  output  1  request toward the TCM controller.
REQ-009 mem_req_ack  input  1  TCM controller request accept.
REQ-010 mem_resp  input  2  TCM controller response, same encoding as port_resp.
REQ-011 gnt  output  2  index of the granted port; 3 is invalid.
REQ-012 gnt_vld  output  1  high while a grant is held; downstream muxes select cmd, addr and wdata by gnt.
REQ-013 timeout_err  output  1  one-cycle pulse when a transaction times out.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACTIVE and WAIT.
REQ-015 IDLE: when port_req is nonzero, the block SHALL select a port round-robin, searching from last_gnt+1 modulo 3, then register gnt, set gnt_vld=1 and move to ACTIVE.
  - Grant latency: request at cycle N, gnt_vld at N+1.
REQ-016 IDLE with port_req=0: the FSM SHALL stay in IDLE with gnt_vld=0 and gnt=3.
REQ-017 ACTIVE: mem_req SHALL equal port_req[gnt], and port_req_ack[gnt] SHALL equal mem_req_ack combinationally; all other port_req_ack bits SHALL be 0.
REQ-018 ACTIVE, when mem_req & mem_req_ack: the FSM SHALL move to WAIT, clear the timeout counter, and drive mem_req=0 from the next cycle.
REQ-019 ACTIVE, when port_req[gnt] drops before the accept: the FSM SHALL return to IDLE with gnt_vld=0.
  - last_gnt SHALL be updated so that the port loses its priority.
REQ-020 WAIT: port_resp for the granted port SHALL equal mem_resp combinationally; all other port_resp fields SHALL be 0.
REQ-021 WAIT, when mem_resp != 0: the FSM SHALL go to IDLE, set last_gnt=gnt, and clear gnt_vld.
  - At least one IDLE bubble cycle SHALL occur between grants.
REQ-022 WAIT, when the counter reaches TIMEOUT-1 with mem_resp == 0, the block SHALL:
  - drive RDY_ER on port_resp[gnt] for that cycle;
  - pulse timeout_err;
  - set last_gnt=gnt and go to IDLE.
REQ-023 The timeout counter SHALL be 8 bits, increment only in WAIT, and saturate at TIMEOUT-1.
REQ-024 When requests are simultaneous, round-robin SHALL guarantee each continuously requesting port a grant within 3 transactions.
REQ-025 A request from a non-granted port SHALL never be acked or responded to.
REQ-026 mem_resp arriving outside WAIT SHALL be ignored.

Reset
REQ-027 While rst=1, the block SHALL hold:
  - state=IDLE, gnt=3, gnt_vld=0, last_gnt=2 (so imem has first priority);
  - counter=0, mem_req=0, port_req_ack=0, port_resp=0, timeout_err=0.
REQ-028 rst asserted mid-transaction SHALL abandon the grant at the next edge without any response to the port.

Verification
REQ-029 The bench SHALL cover these scenarios:
  - Single request: port_req=3'b001, ack in cycle 2, mem_resp=1 two cycles later -> gnt=0, port_req_ack[0]=1, port_resp[1:0]=1; back to IDLE.
  - All requesting after reset: port_req=3'b111 held, every transaction completes -> grant order 0,1,2,0,1.
  - Timeout: TIMEOUT=4, dmem accepted, mem_resp held at 0 -> fourth WAIT cycle gives port_resp[3:2]=2, a timeout_err pulse, and the next grant goes to port 2 if it is requesting.
  - Drop: imem granted and deasserts before mem_req_ack -> IDLE next cycle, no ack or response to imem, dmem granted next.
  - Reset mid-WAIT: rst for one cycle -> all outputs at reset values; a stale mem_resp=1 is ignored.
  - Isolation: dmem granted, random mem_resp -> port_resp[1:0] and port_resp[5:4] stay 0 throughout.
